// File: rtl/mac_pkg.sv
// Shared constants, state type and CRC-32 helper for the MAC receive path.
// Also intended for reuse by the TX FCS inserter.
package mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam int FCS_BYTES   = 4;
  // One payload byte plus the FCS must be held so that the FCS can be stripped.
  localparam int DELAY_DEPTH = FCS_BYTES + 1;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first CRC-32 update for one byte; the register is never inverted.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ reflect32(CRC32_POLY)) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 register with synchronous init and enable.
// The state output is the raw register (no final inversion).
module crc32_d8
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC32_INIT;
    end else if (init) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= crc32_next(crc, data);
    end
  end

endmodule

// File: rtl/mac_rx_framer.sv
// RX framer: strips preamble/SFD, checks FCS and length, strips the FCS and
// emits a tready-less byte stream with tlast/tuser plus per-frame stat pulses.
module mac_rx_framer
  import mac_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int LEN_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_good,
  output logic       stat_crc_err,
  output logic       stat_rx_err,
  output logic       stat_runt,
  output logic       stat_giant
);

  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [LEN_W-1:0] GIANT_LEN = LEN_W'(MAX_FRAME + 1);

  rx_state_t         state, state_next;
  logic              start_frame, take_byte, end_frame;
  logic [LEN_W-1:0]  byte_cnt, byte_cnt_inc;
  logic [7:0]        line [DELAY_DEPTH];
  logic              err, err_now;
  logic [31:0]       crc;
  logic              len_hit, giant_hit, line_full;
  logic              crc_bad, runt, giant_len, bad;

  crc32_d8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (start_frame),
    .en    (take_byte),
    .data  (rx_data),
    .crc   (crc)
  );

  assign byte_cnt_inc = (byte_cnt == LEN_MAX) ? byte_cnt : byte_cnt + 1'b1;
  assign line_full    = byte_cnt >= LEN_W'(DELAY_DEPTH);
  assign len_hit      = byte_cnt_inc == GIANT_LEN;
  assign giant_hit    = take_byte && len_hit;
  assign err_now      = err || rx_error;

  // A frame too short to carry a full FCS is always treated as an FCS failure.
  assign crc_bad   = (crc != CRC32_RESIDUE) || (byte_cnt <= LEN_W'(FCS_BYTES));
  assign runt      = byte_cnt < LEN_W'(MIN_FRAME);
  assign giant_len = byte_cnt > LEN_W'(MAX_FRAME);
  assign bad       = crc_bad || err || runt || giant_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    take_byte   = 1'b0;
    end_frame   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == PREAMBLE_BYTE) begin
            state_next = PREAMBLE;
          end else if (rx_data == SFD_BYTE) begin
            state_next  = DATA;
            start_frame = 1'b1;
          end else begin
            state_next = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!rx_valid) begin
          state_next = IDLE;
        end else if (rx_data == SFD_BYTE) begin
          state_next  = DATA;
          start_frame = 1'b1;
        end else if (rx_data != PREAMBLE_BYTE) begin
          state_next = DROP;
        end
      end
      DATA: begin
        if (!rx_valid) begin
          state_next = IDLE;
          end_frame  = 1'b1;
        end else begin
          take_byte = 1'b1;
          if (len_hit) state_next = DROP;
        end
      end
      DROP: begin
        if (!rx_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt      <= '0;
      err           <= 1'b0;
      // NOTE: the delay line is a handful of flops, so it is cleared on reset like any other state.
      for (int i = 0; i < DELAY_DEPTH; i++) line[i] <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      stat_good     <= 1'b0;
      stat_crc_err  <= 1'b0;
      stat_rx_err   <= 1'b0;
      stat_runt     <= 1'b0;
      stat_giant    <= 1'b0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      stat_good     <= 1'b0;
      stat_crc_err  <= 1'b0;
      stat_rx_err   <= 1'b0;
      stat_runt     <= 1'b0;
      stat_giant    <= 1'b0;

      if (start_frame) begin
        byte_cnt <= '0;
        err      <= 1'b0;
      end

      if (take_byte) begin
        byte_cnt <= byte_cnt_inc;
        err      <= err_now;
        line[0]  <= rx_data;
        for (int i = 1; i < DELAY_DEPTH; i++) line[i] <= line[i-1];
        if (line_full) begin
          m_axis_tdata  <= line[DELAY_DEPTH-1];
          m_axis_tvalid <= 1'b1;
        end
        // Oversized frame: close it out on the byte being evicted, discard the rest.
        if (giant_hit) begin
          m_axis_tlast <= 1'b1;
          m_axis_tuser <= 1'b1;
          stat_giant   <= 1'b1;
          stat_rx_err  <= err_now;
        end
      end

      if (end_frame) begin
        if (line_full) begin
          m_axis_tdata  <= line[DELAY_DEPTH-1];
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= 1'b1;
          m_axis_tuser  <= bad;
        end
        stat_good    <= !bad;
        stat_crc_err <= crc_bad;
        stat_rx_err  <= err;
        stat_runt    <= runt;
        stat_giant   <= giant_len;
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_framer.sv
// Directed self-checking bench for mac_rx_framer: builds frames with a
// bit-serial FCS model and checks beats, tlast/tuser and stat pulses.
module tb_mac_rx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic       stat_good, stat_crc_err, stat_rx_err, stat_runt, stat_giant;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         lasts[$];
  logic       last_user;
  int         n_good, n_crc, n_rxe, n_runt, n_giant;
  int         first_cyc, pay0_cyc, last_cyc, stat_cyc;

  always #5 clk = ~clk;

  mac_rx_framer #(
    .MIN_FRAME (64),
    .MAX_FRAME (1518),
    .LEN_W     (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_error      (rx_error),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .stat_good     (stat_good),
    .stat_crc_err  (stat_crc_err),
    .stat_rx_err   (stat_rx_err),
    .stat_runt     (stat_runt),
    .stat_giant    (stat_giant)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  // Bit-serial reflected CRC-32, one data bit at a time.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if ((r[0] ^ b[k]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] outs();
    return {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
            stat_good, stat_crc_err, stat_rx_err, stat_runt, stat_giant};
  endfunction

  function automatic int data_mism();
    int m;
    m = 0;
    for (int i = 0; i < got.size(); i++)
      if (i >= exp_q.size() || got[i] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic int last_at(input int i);
    return (i < lasts.size()) ? lasts[i] : -1;
  endfunction

  function automatic int n_stats();
    return n_good + n_crc + n_rxe + n_runt + n_giant;
  endfunction

  task automatic clear_acc();
    got.delete();
    exp_q.delete();
    lasts.delete();
    last_user = 1'b0;
    n_good = 0; n_crc = 0; n_rxe = 0; n_runt = 0; n_giant = 0;
    first_cyc = -1; pay0_cyc = -100; last_cyc = -1; stat_cyc = -2;
  endtask

  task automatic observe();
    if (m_axis_tvalid) begin
      if (got.size() == 0) first_cyc = cyc;
      got.push_back(m_axis_tdata);
      if (m_axis_tlast) begin
        lasts.push_back(got.size());
        last_user = m_axis_tuser;
        last_cyc  = cyc;
      end
    end
    if (stat_good || stat_crc_err || stat_rx_err || stat_runt || stat_giant) stat_cyc = cyc;
    n_good  += int'(stat_good);
    n_crc   += int'(stat_crc_err);
    n_rxe   += int'(stat_rx_err);
    n_runt  += int'(stat_runt);
    n_giant += int'(stat_giant);
  endtask

  // Observe what the last edge produced, then drive the next input byte.
  task automatic tick(input logic v, input logic [7:0] d, input logic e);
    @(negedge clk);
    cyc++;
    observe();
    rx_valid = v;
    rx_data  = d;
    rx_error = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input int pre_len, input int plen, input int seed,
                            input bit flip, input int err_idx);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < pre_len; i++) tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < plen; i++) begin
      b = 8'(i + seed);
      exp_q.push_back(b);
      crc = crc_byte(crc, b);
      tick(1'b1, b, (i == err_idx));
      if (i == 0) pay0_cyc = cyc;
    end
    fcs = ~crc;
    if (flip) fcs[0] = ~fcs[0];
    for (int i = 0; i < 4; i++) tick(1'b1, fcs[8*i +: 8], 1'b0);
  endtask

  initial begin
    clear_acc();
    #12;
    check("reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Good 64-byte frame, payload 0x00..0x3B
    clear_acc();
    send_frame(7, 60, 0, 1'b0, -1);
    idle(4);
    check("good_beats", got.size(), 60);
    check("good_data", data_mism(), 0);
    check("good_nlast", lasts.size(), 1);
    check("good_last_pos", last_at(0), 60);
    check("good_tuser", 32'(last_user), 0);
    check("good_stat_good", n_good, 1);
    check("good_no_err_stats", n_crc + n_rxe + n_runt + n_giant, 0);
    check("good_latency", first_cyc - pay0_cyc, 6);
    check("good_stat_with_tlast", stat_cyc, last_cyc);

    // Same frame with FCS LSB flipped
    clear_acc();
    send_frame(7, 60, 0, 1'b1, -1);
    idle(4);
    check("crc_beats", got.size(), 60);
    check("crc_tuser", 32'(last_user), 1);
    check("crc_stat_crc", n_crc, 1);
    check("crc_stat_good", n_good, 0);

    // Runt: L = 50
    clear_acc();
    send_frame(7, 46, 8'h40, 1'b0, -1);
    idle(4);
    check("runt_beats", got.size(), 46);
    check("runt_tuser", 32'(last_user), 1);
    check("runt_stat_runt", n_runt, 1);
    check("runt_stat_crc", n_crc, 0);
    check("runt_stat_good", n_good, 0);

    // No payload (L = 4, short preamble): no beat, runt and crc pulses
    clear_acc();
    send_frame(0, 0, 0, 1'b0, -1);
    idle(4);
    check("tiny_beats", got.size(), 0);
    check("tiny_stat_runt", n_runt, 1);
    check("tiny_stat_crc", n_crc, 1);
    check("tiny_stat_good", n_good, 0);

    // Maximum legal frame: L = 1518
    clear_acc();
    send_frame(7, 1514, 7, 1'b0, -1);
    idle(4);
    check("max_beats", got.size(), 1514);
    check("max_data", data_mism(), 0);
    check("max_tuser", 32'(last_user), 0);
    check("max_stat_good", n_good, 1);
    check("max_stat_giant", n_giant, 0);

    // Giant: L = 1519
    clear_acc();
    send_frame(7, 1515, 3, 1'b0, -1);
    idle(4);
    check("giant_beats", got.size(), 1514);
    check("giant_data", data_mism(), 0);
    check("giant_nlast", lasts.size(), 1);
    check("giant_last_pos", last_at(0), 1514);
    check("giant_tuser", 32'(last_user), 1);
    check("giant_stat_giant", n_giant, 1);
    check("giant_stat_good", n_good, 0);
    check("giant_stat_crc", n_crc, 0);

    // rx_error on payload byte 10, valid FCS
    clear_acc();
    send_frame(7, 60, 8'h20, 1'b0, 10);
    idle(4);
    check("rxerr_beats", got.size(), 60);
    check("rxerr_tuser", 32'(last_user), 1);
    check("rxerr_stat_rx", n_rxe, 1);
    check("rxerr_stat_crc", n_crc, 0);
    check("rxerr_stat_good", n_good, 0);

    // rx_error with rx_valid low in IDLE
    clear_acc();
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h0F, 1'b1);
    idle(3);
    check("carrier_ext_beats", got.size(), 0);
    check("carrier_ext_stats", n_stats(), 0);

    // Back-to-back 64-byte frames with a single idle cycle
    clear_acc();
    send_frame(7, 60, 8'h10, 1'b0, -1);
    tick(1'b0, 8'h00, 1'b0);
    send_frame(7, 60, 8'h80, 1'b0, -1);
    idle(4);
    check("b2b_beats", got.size(), 120);
    check("b2b_data", data_mism(), 0);
    check("b2b_nlast", lasts.size(), 2);
    check("b2b_last0_pos", last_at(0), 60);
    check("b2b_last1_pos", last_at(1), 120);
    check("b2b_stat_good", n_good, 2);
    check("b2b_err_stats", n_crc + n_rxe + n_runt + n_giant, 0);

    // Bad preamble byte: dropped silently, a later 0xD5 is ignored
    clear_acc();
    tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'h12, 1'b0);
    tick(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b1, 8'(i), 1'b0);
    idle(4);
    check("badpre_beats", got.size(), 0);
    check("badpre_stats", n_stats(), 0);

    // Reset pulse at payload byte 20
    clear_acc();
    for (int i = 0; i < 7; i++) tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 21; i++) tick(1'b1, 8'(i), 1'b0);
    check("rst_beats_before", got.size(), 15);
    rst_n = 1'b0;
    #1;
    check("rst_outputs_cleared", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    clear_acc();
    idle(4);
    check("rst_quiet_beats", got.size(), 0);
    check("rst_quiet_stats", n_stats(), 0);
    send_frame(7, 60, 8'h55, 1'b0, -1);
    idle(4);
    check("rst_next_beats", got.size(), 60);
    check("rst_next_data", data_mism(), 0);
    check("rst_next_nlast", lasts.size(), 1);
    check("rst_next_good", n_good, 1);
    check("rst_next_tuser", 32'(last_user), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
